// File: rtl/mem_write_checker.sv
// Self-checking monitor for the MIPS data-memory store bus.
// Optional store capture: define MEM_WRITE_CHECKER_CAPTURE_EN.
module mem_write_checker #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_EXP     = 4,
  parameter int IGNORE_ADDR = 80,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 16,
  localparam int IDX_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              strict,
  input  logic [IDX_W:0]    exp_count,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              done,
  output logic              pass,
  output logic [2:0]        fail_code,
  output logic [IDX_W:0]    match_cnt,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [ADDR_W-1:0] bad_addr,
  output logic [DATA_W-1:0] bad_data
);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_PASS, S_FAIL
  } state_t;

  localparam logic [2:0] FC_NONE = 3'd0;
  localparam logic [2:0] FC_DATA = 3'd1;
  localparam logic [2:0] FC_ADDR = 3'd2;
  localparam logic [2:0] FC_TOUT = 3'd3;
  localparam logic [2:0] FC_CFG  = 3'd4;

  localparam logic [IDX_W:0] NUM_L =
    (IDX_W+1)'(NUM_EXP);
  localparam logic [CNT_W-1:0] TOUT_L =
    CNT_W'(TIMEOUT_CYC);
  localparam logic [ADDR_W-1:0] IGN_L =
    ADDR_W'(IGNORE_ADDR);

  state_t            state_q, state_d;
  logic              strict_q, strict_d;
  logic [IDX_W:0]    cnt_q, cnt_d;
  logic [IDX_W:0]    match_d;
  logic [CNT_W-1:0]  cyc_d;
  logic [2:0]        code_d;
  logic              clr_bad;
  logic              cap_bad;

  logic [ADDR_W-1:0] tab_addr [NUM_EXP];
  logic [DATA_W-1:0] tab_data [NUM_EXP];
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;
  logic              idx_ok;
  logic              hit_a;
  logic              hit_d;

  assign idx_ok = ({1'b0, exp_idx} < NUM_L);
  assign e_addr = tab_addr[match_cnt[IDX_W-1:0]];
  assign e_data = tab_data[match_cnt[IDX_W-1:0]];
  assign hit_a  = (dataadr == e_addr);
  assign hit_d  = (writedata == e_data);

  // Expected table: loadable only while idle, survives reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && exp_we && idx_ok) begin
      tab_addr[exp_idx] <= exp_addr;
      tab_data[exp_idx] <= exp_data;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      strict_q  <= 1'b0;
      cnt_q     <= '0;
      match_cnt <= '0;
      cycle_cnt <= '0;
      fail_code <= FC_NONE;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state_q   <= state_d;
      strict_q  <= strict_d;
      cnt_q     <= cnt_d;
      match_cnt <= match_d;
      cycle_cnt <= cyc_d;
      fail_code <= code_d;
      done      <= (state_d == S_PASS) ||
                   (state_d == S_FAIL);
      pass      <= (state_d == S_PASS);
    end
  end

  // Next-state: start handling, store compare, timeout.
  always_comb begin
    state_d  = state_q;
    strict_d = strict_q;
    cnt_d    = cnt_q;
    match_d  = match_cnt;
    cyc_d    = cycle_cnt;
    code_d   = fail_code;
    clr_bad  = 1'b0;
    cap_bad  = 1'b0;
    unique case (state_q)
      S_RUN: begin
        cyc_d = cycle_cnt + CNT_W'(1);
        if (memwrite) begin
          if (hit_a && hit_d) begin
            match_d = match_cnt + (IDX_W+1)'(1);
            if (match_d == cnt_q)
              state_d = S_PASS;
          end else if (dataadr == IGN_L) begin
            state_d = S_RUN;
          end else if (hit_a) begin
            state_d = S_FAIL;
            code_d  = FC_DATA;
            cap_bad = 1'b1;
          end else if (strict_q) begin
            state_d = S_FAIL;
            code_d  = FC_ADDR;
            cap_bad = 1'b1;
          end
        end
        if (state_d == S_RUN && cyc_d == TOUT_L) begin
          state_d = S_FAIL;
          code_d  = FC_TOUT;
        end
      end
      default: begin
        if (start) begin
          clr_bad  = 1'b1;
          strict_d = strict;
          cnt_d    = exp_count;
          match_d  = '0;
          cyc_d    = '0;
          code_d   = FC_NONE;
          if (exp_count == '0) begin
            state_d = S_PASS;
          end else if (exp_count > NUM_L) begin
            state_d = S_FAIL;
            code_d  = FC_CFG;
          end else begin
            state_d = S_RUN;
          end
        end
      end
    endcase
  end

`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
  // Latch the first offending store on a data/address failure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_addr <= '0;
      bad_data <= '0;
    end else if (clr_bad) begin
      bad_addr <= '0;
      bad_data <= '0;
    end else if (cap_bad) begin
      bad_addr <= dataadr;
      bad_data <= writedata;
    end
  end
`else
  logic unused_cap;
  assign unused_cap = clr_bad ^ cap_bad;
  assign bad_addr   = '0;
  assign bad_data   = '0;
`endif

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-checking monitor for the multi-cycle MIPS data-memory write bus (memwrite/dataadr/writedata).
- Successor to the single hard-coded "store 7 to address 84" pass check.
- Compares observed stores against a loadable, ordered table of up to NUM_EXP expected (address, data) pairs.
- Supports an ignore address, a strict/lenient mode and a cycle timeout; produces a sticky pass/fail verdict with a failure code.

Parameters:
- ADDR_W, 32, dataadr / table address width
- DATA_W, 32, writedata / table data width
- NUM_EXP, 4, expected-table depth (>=1); IDX_W = max(1, clog2(NUM_EXP))
- IGNORE_ADDR, 80, stores to this address are always ignored (scratch location)
- TIMEOUT_CYC, 1000, RUN cycles allowed before timeout failure
- CNT_W, 16, cycle counter width (2^CNT_W-1 >= TIMEOUT_CYC)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin checking; accepted in IDLE, PASS or FAIL
- strict  in  1  sampled on start: 1 = unexpected stores fail
- exp_count  in  IDX_W+1  number of valid table entries, sampled on start
- exp_we  in  1  table write strobe, honoured in IDLE only
- exp_idx  in  IDX_W  table write index
- exp_addr  in  ADDR_W  table address value
- exp_data  in  DATA_W  table data value
- memwrite  in  1  monitored store strobe
- dataadr  in  ADDR_W  monitored store address
- writedata  in  DATA_W  monitored store data
- done  out  1  verdict reached (PASS or FAIL)
- pass  out  1  1 in PASS
- fail_code  out  3  0 none, 1 DATA, 2 ADDR, 3 TIMEOUT, 4 CFG
- match_cnt  out  IDX_W+1  entries matched so far
- cycle_cnt  out  CNT_W  RUN cycles elapsed
- bad_addr  out  ADDR_W  first offending address (optional feature)
- bad_data  out  DATA_W  first offending data (optional feature)

Behaviour:
- Reset (async, immediate):
  - state IDLE; all outputs 0.
  - Table contents are not cleared.
- States: IDLE, RUN, PASS, FAIL; all outputs are registered.
- Table writes: exp_we writes entry[exp_idx] on the clock edge, only in IDLE. exp_idx >= NUM_EXP is ignored.
- start, from IDLE/PASS/FAIL:
  - clears match_cnt, cycle_cnt, fail_code and bad_*; latches strict and exp_count.
  - exp_count == 0 -> PASS next cycle.
  - exp_count > NUM_EXP -> FAIL, code 4.
  - otherwise -> RUN.
  - start while in RUN is ignored.
- RUN, each cycle:
  - cycle_cnt increments.
  - On memwrite=1, compare with E = entry[match_cnt], in priority order:
    1. dataadr==E.addr and writedata==E.data -> match_cnt+1; if the new value equals exp_count -> PASS.
    2. dataadr==IGNORE_ADDR -> ignored.
    3. dataadr==E.addr, data differs -> FAIL, code 1.
    4. any other address: strict -> FAIL, code 2; lenient -> ignored.
  - memwrite=0: no compare.
- Timeout: FAIL with code 3 on the edge where cycle_cnt would reach TIMEOUT_CYC. If a final match occurs in the same cycle, PASS wins.
- Latency: the verdict appears on outputs one clock after the deciding memwrite cycle.
- PASS/FAIL are sticky until reset or start; counters freeze there.
- Reset mid-RUN aborts with no verdict.

Optional Feature:
- Macro MEM_WRITE_CHECKER_CAPTURE_EN.
- Defined: on the edge entering FAIL with code 1 or 2, bad_addr/bad_data latch the offending dataadr/writedata. They hold until start or reset.
- Undefined: bad_addr/bad_data are tied to 0 and no capture registers exist.

Test Plan:
- Table {84,7}, exp_count 1, lenient, start. Stores (80,5) then (84,7) -> 80 ignored; one cycle after the 84 store: done=1, pass=1, match_cnt=1, fail_code=0.
- Same table, store (84,6) -> done=1, pass=0, fail_code=1; with CAPTURE_EN, bad_addr=84, bad_data=6.
- Table {84,7}, strict=1, store (88,1) -> fail_code=2. Repeat with strict=0 -> no verdict; a later (84,7) gives PASS.
- TIMEOUT_CYC=16, no stores -> FAIL, fail_code=3, exactly 16 cycles after entering RUN. A final match in cycle 16 gives PASS instead.
- Table {84,7},{88,0x5F3F}, exp_count 2, lenient. Stores (88,0x5F3F), (84,7), (88,0x5F3F) -> first store ignored, then match_cnt 1 -> 2, PASS.
- Config and reset edges:
  - exp_count=5 with NUM_EXP=4 -> FAIL, code 4.
  - exp_count=0 -> PASS.
  - reset asserted mid-RUN -> all outputs 0 immediately, without waiting for clk.
